// File: rtl/mul_en_12_if.sv
// Operand/product bundle for the 12-bit floating-point multiplier.
// The slave side is the multiplier; the master side is whoever feeds it.
interface mul_en_12_if;
  logic        en_i;
  logic        valid_i;
  logic [11:0] data_1_i;
  logic [11:0] data_2_i;
  logic        valid_o;
  logic [11:0] data_prod_o;

  modport slave (
    input  en_i,
    input  valid_i,
    input  data_1_i,
    input  data_2_i,
    output valid_o,
    output data_prod_o
  );

  modport master (
    output en_i,
    output valid_i,
    output data_1_i,
    output data_2_i,
    input  valid_o,
    input  data_prod_o
  );
endinterface

// File: rtl/mul_en_12.sv
// 3-stage pipelined multiplier for the 1/5/6 (bias 15) neuron number format.
// Stage 1 splits operands, stage 2 multiplies mantissas and rebiases the
// exponent, stage 3 normalises, rounds half-up and clamps. A single enable
// freezes every register, data and valid alike.
module mul_en_12 (
  input  logic        clk_i,
  input  logic        rst_n_i,
  mul_en_12_if.slave  bus
);

  // Stage 1 state
  logic       r_s1_valid;
  logic       r_s1_sign;
  logic       r_s1_zero;
  logic [6:0] r_s1_esum;
  logic [6:0] r_s1_man_a;
  logic [6:0] r_s1_man_b;

  // Stage 2 state
  logic        r_s2_valid;
  logic        r_s2_sign;
  logic        r_s2_zero;
  logic [13:0] r_s2_prod;
  logic [7:0]  r_s2_eb;     // two's complement, range -15..47

  // Stage 3 state (drives the outputs)
  logic        r_valid_o;
  logic [11:0] r_prod_o;

  // Stage 1 combinational
  logic       w_s1_zero;
  logic [6:0] w_s1_esum;

  assign w_s1_zero = (bus.data_1_i[10:6] == 5'd0) | (bus.data_2_i[10:6] == 5'd0);
  assign w_s1_esum = {2'b00, bus.data_1_i[10:6]} + {2'b00, bus.data_2_i[10:6]};

  // Stage 2 combinational
  logic [13:0] w_s2_prod;
  logic [7:0]  w_s2_eb;

  assign w_s2_prod = {7'd0, r_s1_man_a} * {7'd0, r_s1_man_b};
  assign w_s2_eb   = {1'b0, r_s1_esum} - 8'd15;

  // Stage 3 combinational: normalise, round, classify
  logic        w_hi;
  logic [5:0]  w_man_raw;
  logic        w_rnd;
  logic [6:0]  w_man_sum;
  logic [8:0]  w_exp;
  logic        w_underflow;
  logic        w_overflow;
  logic [11:0] w_prod_next;

  // Product of two 1.x mantissas lies in [1,4); bit 13 marks the [2,4) case.
  assign w_hi      = r_s2_prod[13];
  assign w_man_raw = w_hi ? r_s2_prod[12:7] : r_s2_prod[11:6];
  assign w_rnd     = w_hi ? r_s2_prod[6]    : r_s2_prod[5];
  assign w_man_sum = {1'b0, w_man_raw} + {6'd0, w_rnd};

  // Sign-extended 9-bit exponent absorbs both the normalise and the
  // rounding-carry increments without wrapping.
  assign w_exp = {r_s2_eb[7], r_s2_eb} + {8'd0, w_hi} + {8'd0, w_man_sum[6]};

  assign w_underflow = w_exp[8] | (w_exp == 9'd0);
  assign w_overflow  = ~w_exp[8] & (w_exp[7:5] != 3'd0);

  // Result selection: zero beats underflow beats saturation beats normal.
  always_comb begin
    w_prod_next = {r_s2_sign, w_exp[4:0], w_man_sum[5:0]};
    if (r_s2_zero) begin
      w_prod_next = 12'h000;
    end else if (w_underflow) begin
      w_prod_next = 12'h000;
    end else if (w_overflow) begin
      w_prod_next = {r_s2_sign, 5'd31, 6'h3F};
    end
  end

  // Stage 1: capture sign, zero flag, exponent sum and hidden-bit mantissas.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_esum  <= 7'd0;
      r_s1_man_a <= 7'd0;
      r_s1_man_b <= 7'd0;
    end else if (bus.en_i) begin
      r_s1_valid <= bus.valid_i;
      r_s1_sign  <= bus.data_1_i[11] ^ bus.data_2_i[11];
      r_s1_zero  <= w_s1_zero;
      r_s1_esum  <= w_s1_esum;
      r_s1_man_a <= {1'b1, bus.data_1_i[5:0]};
      r_s1_man_b <= {1'b1, bus.data_2_i[5:0]};
    end
  end

  // Stage 2: mantissa product and rebiased exponent; flags ride along.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_prod  <= 14'd0;
      r_s2_eb    <= 8'd0;
    end else if (bus.en_i) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_zero  <= r_s1_zero;
      r_s2_prod  <= w_s2_prod;
      r_s2_eb    <= w_s2_eb;
    end
  end

  // Stage 3: register the packed result so the outputs come straight from flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid_o <= 1'b0;
      r_prod_o  <= 12'h000;
    end else if (bus.en_i) begin
      r_valid_o <= r_s2_valid;
      r_prod_o  <= w_prod_next;
    end
  end

  assign bus.valid_o     = r_valid_o;
  assign bus.data_prod_o = r_prod_o;

endmodule

// File: tb/tb_mul_en_12.sv
// Directed bench for mul_en_12 plus a short randomised run against a
// behavioural model of the number format.
module tb_mul_en_12;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mul_en_12_if bus ();

  mul_en_12 dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for the falling edge, then present one input set for the next rising edge.
  task automatic apply(input logic en, input logic v, input logic [11:0] a, input logic [11:0] b);
    @(negedge clk);
    bus.en_i     = en;
    bus.valid_i  = v;
    bus.data_1_i = a;
    bus.data_2_i = b;
  endtask

  // Behavioural model built from real-valued reasoning about the format.
  function automatic logic [11:0] ref_mul(input logic [11:0] a, input logic [11:0] b);
    int ea;
    int eb;
    int p;
    int e;
    int m;
    int r;
    logic s;
    logic [11:0] res;
    ea = int'(a[10:6]);
    eb = int'(b[10:6]);
    s  = a[11] ^ b[11];
    if (ea == 0 || eb == 0) return 12'h000;
    p = (64 + int'(a[5:0])) * (64 + int'(b[5:0]));
    e = ea + eb - 15;
    if (p >= 8192) begin
      m = (p / 128) % 64;
      r = (p / 64) % 2;
      e = e + 1;
    end else begin
      m = (p / 64) % 64;
      r = (p / 32) % 2;
    end
    m = m + r;
    if (m == 64) begin
      m = 0;
      e = e + 1;
    end
    if (e <= 0) return 12'h000;
    if (e > 31) return {s, 11'h7FF};
    res = {s, e[4:0], m[5:0]};
    return res;
  endfunction

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.en_i     = 1'b1;
    bus.valid_i  = 1'b1;
    bus.data_1_i = 12'h3E0;
    bus.data_2_i = 12'h3E0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.valid_o !== 1'b0 || bus.data_prod_o !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got valid=%b prod=%h, want valid=0 prod=000", i, bus.valid_o, bus.data_prod_o);
      end else $display("reset_hold[%0d]: valid=%b prod=%h", i, bus.valid_o, bus.data_prod_o);
    end
    bus.valid_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [11:0] exp_p [0:1];
    exp_p[0] = 12'h408;
    exp_p[1] = 12'hC20;
    apply(1'b1, 1'b1, 12'h3E0, 12'h3E0);
    apply(1'b1, 1'b1, 12'hC00, 12'h3E0);
    apply(1'b1, 1'b0, 12'h000, 12'h000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_prod_o !== exp_p[i]) begin
        errors++;
        $display("FAIL basic[%0d]: got valid=%b prod=%h, want valid=1 prod=%h", i, bus.valid_o, bus.data_prod_o, exp_p[i]);
      end else $display("basic[%0d]: prod=%h", i, bus.data_prod_o);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_tail: got valid=%b, want valid=0", bus.valid_o);
    end
  endtask

  task automatic test_rounding();
    logic [11:0] op_a  [0:2];
    logic [11:0] op_b  [0:2];
    logic [11:0] exp_p [0:2];
    op_a[0] = 12'h3C1; op_b[0] = 12'h3C1; exp_p[0] = 12'h3C2;
    op_a[1] = 12'h3E0; op_b[1] = 12'h3C3; exp_p[1] = 12'h3E5;
    op_a[2] = 12'h3DA; op_b[2] = 12'h3DB; exp_p[2] = 12'h400;
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, op_a[i], op_b[i]);
    apply(1'b1, 1'b0, 12'h000, 12'h000);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_prod_o !== exp_p[i]) begin
        errors++;
        $display("FAIL round[%0d]: got valid=%b prod=%h, want valid=1 prod=%h", i, bus.valid_o, bus.data_prod_o, exp_p[i]);
      end else $display("round[%0d]: %h x %h = %h", i, op_a[i], op_b[i], bus.data_prod_o);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL round_tail: got valid=%b, want valid=0", bus.valid_o);
    end
  endtask

  task automatic test_special();
    logic [11:0] op_a  [0:4];
    logic [11:0] op_b  [0:4];
    logic [11:0] exp_p [0:4];
    op_a[0] = 12'h000; op_b[0] = 12'h7FF; exp_p[0] = 12'h000;
    op_a[1] = 12'h8C5; op_b[1] = 12'h000; exp_p[1] = 12'h000;
    op_a[2] = 12'h040; op_b[2] = 12'h040; exp_p[2] = 12'h000;
    op_a[3] = 12'h7FF; op_b[3] = 12'h7FF; exp_p[3] = 12'h7FF;
    op_a[4] = 12'hFFF; op_b[4] = 12'h7FF; exp_p[4] = 12'hFFF;
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b1, op_a[i], op_b[i]);
      if (i >= 3) begin
        checks++;
        if (bus.valid_o !== 1'b1 || bus.data_prod_o !== exp_p[i-3]) begin
          errors++;
          $display("FAIL special[%0d]: got valid=%b prod=%h, want valid=1 prod=%h", i-3, bus.valid_o, bus.data_prod_o, exp_p[i-3]);
        end else $display("special[%0d]: %h x %h = %h", i-3, op_a[i-3], op_b[i-3], bus.data_prod_o);
      end
    end
    for (int i = 2; i < 5; i++) begin
      apply(1'b1, 1'b0, 12'h000, 12'h000);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_prod_o !== exp_p[i]) begin
        errors++;
        $display("FAIL special[%0d]: got valid=%b prod=%h, want valid=1 prod=%h", i, bus.valid_o, bus.data_prod_o, exp_p[i]);
      end else $display("special[%0d]: %h x %h = %h", i, op_a[i], op_b[i], bus.data_prod_o);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_stall();
    apply(1'b1, 1'b1, 12'h3E0, 12'h3E0);
    apply(1'b1, 1'b1, 12'hC00, 12'h3E0);
    apply(1'b1, 1'b1, 12'h3C1, 12'h3C1);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) apply(1'b0, 1'b1, 12'($urandom), 12'($urandom));
      else       apply(1'b1, 1'b0, 12'h000, 12'h000);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_prod_o !== 12'h408) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b prod=%h, want valid=1 prod=408", i, bus.valid_o, bus.data_prod_o);
      end else $display("stall_hold[%0d]: prod=%h", i, bus.data_prod_o);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_prod_o !== 12'hC20) begin
      errors++;
      $display("FAIL stall_resume0: got valid=%b prod=%h, want valid=1 prod=c20", bus.valid_o, bus.data_prod_o);
    end else $display("stall_resume0: prod=%h", bus.data_prod_o);
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_prod_o !== 12'h3C2) begin
      errors++;
      $display("FAIL stall_resume1: got valid=%b prod=%h, want valid=1 prod=3c2", bus.valid_o, bus.data_prod_o);
    end else $display("stall_resume1: prod=%h", bus.data_prod_o);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_tail[%0d]: got valid=%b, want valid=0", i, bus.valid_o);
      end
    end
  endtask

  task automatic test_reset_midstream();
    apply(1'b1, 1'b1, 12'h3E0, 12'h3E0);
    apply(1'b1, 1'b1, 12'h3C1, 12'h3C1);
    apply(1'b1, 1'b1, 12'hC00, 12'h3E0);
    apply(1'b1, 1'b1, 12'h7FF, 12'h7FF);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_prod_o !== 12'h408) begin
      errors++;
      $display("FAIL rst_pre: got valid=%b prod=%h, want valid=1 prod=408", bus.valid_o, bus.data_prod_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.data_prod_o !== 12'h000) begin
      errors++;
      $display("FAIL rst_async: got valid=%b prod=%h, want valid=0 prod=000", bus.valid_o, bus.data_prod_o);
    end else $display("rst_async: outputs cleared between edges");
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.data_prod_o !== 12'h000) begin
      errors++;
      $display("FAIL rst_over_en: got valid=%b prod=%h, want valid=0 prod=000", bus.valid_o, bus.data_prod_o);
    end
    rst_n        = 1'b1;
    bus.en_i     = 1'b1;
    bus.valid_i  = 1'b1;
    bus.data_1_i = 12'h3E0;
    bus.data_2_i = 12'h3C3;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 12'h000, 12'h000);
      checks++;
      if (bus.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_flush[%0d]: got valid=%b, want valid=0", i, bus.valid_o);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_prod_o !== 12'h3E5) begin
      errors++;
      $display("FAIL rst_first: got valid=%b prod=%h, want valid=1 prod=3e5", bus.valid_o, bus.data_prod_o);
    end else $display("rst_first: prod=%h", bus.data_prod_o);
  endtask

  task automatic test_random();
    logic        m_v [0:2];
    logic [11:0] m_d [0:2];
    logic        en;
    logic        v;
    logic [11:0] a;
    logic [11:0] b;
    @(negedge clk);
    rst_n = 1'b0;
    bus.en_i = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = 12'h000;
    end
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      checks++;
      if (bus.valid_o !== m_v[2] || bus.data_prod_o !== m_d[2]) begin
        errors++;
        $display("FAIL rand[%0d]: got valid=%b prod=%h, want valid=%b prod=%h", n, bus.valid_o, bus.data_prod_o, m_v[2], m_d[2]);
      end else if (m_v[2]) $display("rand[%0d]: prod=%h", n, bus.data_prod_o);
      en = ($urandom_range(3) != 0);
      v  = ($urandom_range(4) > 1);
      a  = 12'($urandom);
      b  = 12'($urandom);
      if ($urandom_range(3) == 0) a[10:6] = 5'($urandom_range(10, 20));
      if ($urandom_range(3) == 0) b[10:6] = 5'($urandom_range(10, 20));
      bus.en_i = en;
      bus.valid_i = v;
      bus.data_1_i = a;
      bus.data_2_i = b;
      if (en) begin
        m_v[2] = m_v[1];
        m_d[2] = m_d[1];
        m_v[1] = m_v[0];
        m_d[1] = m_d[0];
        m_v[0] = v;
        m_d[0] = ref_mul(a, b);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_stall();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
